// File: rtl/rv64_mem_port_arbiter.sv
// rv64_mem_port_arbiter: shares one memory port between fetch and data, with locked AMO read-modify-write
module rv64_mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_amo,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, AMO_WR} state_t;

    state_t            state;
    logic [CW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] amo_res;
    logic [1:0]        amo_q;
    logic              fetch_q;
    logic              we_q;
    logic              store_q;
    logic              fetch_win;

    // Fetch only wins a contested cycle once data has been granted STARVE_MAX times in a row
    always_comb begin
        fetch_win = i_req && (!d_req || starve_cnt == CW'(STARVE_MAX));
        i_gnt = !reset && state == IDLE && fetch_win;
        d_gnt = !reset && state == IDLE && d_req && !fetch_win;
        store_q = !fetch_q && amo_q == 2'b00 && we_q;
        amo_res = amo_q == 2'b01 ? old_q + wdata_q : amo_q == 2'b10 ? old_q ^ wdata_q : old_q & wdata_q;
        mem_req = state == ISSUE || state == AMO_WR;
        mem_we = (state == ISSUE && store_q) || state == AMO_WR;
        mem_addr = addr_q;
        mem_wdata = state == AMO_WR ? amo_res : wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            starve_cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            old_q <= '0;
            amo_q <= 2'b00;
            fetch_q <= 1'b0;
            we_q <= 1'b0;
            i_rvalid <= 1'b0;
            i_rdata <= '0;
            d_rvalid <= 1'b0;
            d_rdata <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: if (i_gnt || d_gnt) begin
                    state <= ISSUE;
                    fetch_q <= i_gnt;
                    addr_q <= i_gnt ? i_addr : d_addr;
                    we_q <= d_gnt && d_we;
                    amo_q <= d_gnt ? d_amo : 2'b00;
                    wdata_q <= d_wdata;
                    starve_cnt <= (d_gnt && i_req) ?
                        (starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1) : '0;
                end
                ISSUE: if (mem_ready) begin
                    state <= store_q ? IDLE : RWAIT;
                    d_rvalid <= store_q;
                    if (store_q) d_rdata <= '0;
                end
                RWAIT: if (mem_rvalid) begin
                    state <= (!fetch_q && amo_q != 2'b00) ? AMO_WR : IDLE;
                    if (fetch_q) begin
                        i_rvalid <= 1'b1;
                        i_rdata <= mem_rdata;
                    end else if (amo_q == 2'b00) begin
                        d_rvalid <= 1'b1;
                        d_rdata <= mem_rdata;
                    end else begin
                        old_q <= mem_rdata;
                    end
                end
                AMO_WR: if (mem_ready) begin
                    state <= IDLE;
                    d_rvalid <= 1'b1;
                    d_rdata <= old_q;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
